// File: rtl/lout_port_dist_pkg.sv
// lout_port_dist_pkg: bridge-wide defines and shared helpers for the port distributor.
`ifndef LOUT_BRIDGE_DEFINES
`define LOUT_BRIDGE_DEFINES
`define NUM_PORTS 4
`define LL_PG_ASZ 7
`define PQ_SLICE(p, w) (p)*(w) +: (w)
`define PAR_LEN_W 14
`define PAR_VLAN_W 12
`define FIB_MAC_W 48
`define FIB_PORT_W `NUM_PORTS
`endif

package lout_port_dist_pkg;
  localparam int DROP_W = 16;
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == {DROP_W{1'b1}}) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/lout_port_dist_fifo.sv
// dist_port_fifo: per-port page FIFO; storage is unreset, pointers wrap modulo QDEPTH.
module dist_port_fifo #(
  parameter int QDEPTH = 4,
  parameter int PG_ASZ = 7,
  localparam int AW = $clog2(QDEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [PG_ASZ-1:0] din,
  output logic [PG_ASZ-1:0] dout,
  output logic [CW-1:0]     count
);
  logic [PG_ASZ-1:0] mem_q [QDEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic push_ok, pop_ok;
  always_comb begin
    push_ok = push && (cnt_q != CW'(QDEPTH));
    pop_ok = pop && (cnt_q != '0);
    wr_d = wr_q + AW'(push_ok);
    rd_d = rd_q + AW'(pop_ok);
    cnt_d = cnt_q + CW'(push_ok) - CW'(pop_ok);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) if (push_ok) mem_q[wr_q] <= din;
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
endmodule

// File: rtl/lout_port_dist.sv
// lout_port_dist: fans an accepted forwarding decision's start page out to every masked port FIFO.
module lout_port_dist
  import lout_port_dist_pkg::*;
#(
  parameter int NUM_PORTS = `NUM_PORTS,
  parameter int QDEPTH = 4,
  parameter int PG_ASZ = `LL_PG_ASZ
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        lout_srdy,
  output logic                        lout_drdy,
  input  logic [PG_ASZ-1:0]           lout_start,
  input  logic [NUM_PORTS-1:0]        lout_dst_vld,
  output logic [NUM_PORTS-1:0]        pq_srdy,
  input  logic [NUM_PORTS-1:0]        pq_drdy,
  output logic [NUM_PORTS*PG_ASZ-1:0] pq_page,
  output logic [DROP_W-1:0]           drop_cnt
);
  localparam int CW = $clog2(QDEPTH) + 1;
  logic [NUM_PORTS-1:0] full, push, pop;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic accept;
  // Fullness uses registered counts only, so a same-cycle pop never frees a slot.
  always_comb begin
    lout_drdy = !reset && ((lout_dst_vld & full) == '0);
    accept = lout_srdy && lout_drdy;
    push = accept ? lout_dst_vld : '0;
    pop = pq_drdy & pq_srdy;
    drop_d = (accept && lout_dst_vld == '0) ? sat_inc(drop_q) : drop_q;
  end
  always_ff @(posedge clk) drop_q <= reset ? '0 : drop_d;
  assign drop_cnt = drop_q;
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    logic [CW-1:0] count;
    dist_port_fifo #(.QDEPTH(QDEPTH), .PG_ASZ(PG_ASZ)) u_fifo (
      .clk(clk),
      .reset(reset),
      .push(push[i]),
      .pop(pop[i]),
      .din(lout_start),
      .dout(pq_page[`PQ_SLICE(i, PG_ASZ)]),
      .count(count)
    );
    assign full[i] = (count == CW'(QDEPTH));
    assign pq_srdy[i] = (count != '0);
  end
endmodule
